// File: rtl/cp0_trap_ctrl_pkg.sv
// Shared encodings and helpers for the CP0 trap sequencer.
package cp0_trap_ctrl_pkg;

    // Next-PC source selection handed to the fetch stage
    typedef enum logic [1:0] {
        NPC_SEL_SEQ     = 2'b00,
        NPC_SEL_HANDLER = 2'b01,
        NPC_SEL_EPC     = 2'b10
    } npc_sel_e;

    // Sequencer state: IDLE accepts traps, HOLD drains the pipeline
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [4:0]  EXC_INT          = 5'd0;
    localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;
    localparam int          CNT_W            = 4;

    // EPC points at the branch when the faulting instruction sits in its delay slot
    function automatic logic [31:0] epc_calc(input logic [31:0] pc, input logic bd);
        logic [31:0] base;
        base = {pc[31:2], 2'b00};
        return bd ? (base - 32'd4) : base;
    endfunction

endpackage

// File: rtl/cp0_trap_ctrl_if.sv
// M-stage request and CP0/pipeline response bundle for the trap sequencer.
interface cp0_trap_ctrl_if;
    import cp0_trap_ctrl_pkg::*;

    logic        m_valid;
    logic        m_stall;
    logic [4:0]  m_exccode;
    logic [31:0] m_pc;
    logic        m_bd;
    logic        m_eret;

    logic        trap;
    logic [4:0]  trap_code;
    logic [31:0] trap_pc;
    logic        trap_bd;
    logic        eret_go;
    logic        flush;
    npc_sel_e    npc_sel;
    logic        busy;

    // Pipeline / CP0 side
    modport master (
        output m_valid, m_stall, m_exccode, m_pc, m_bd, m_eret,
        input  trap, trap_code, trap_pc, trap_bd, eret_go, flush, npc_sel, busy
    );

    // Trap sequencer side
    modport slave (
        input  m_valid, m_stall, m_exccode, m_pc, m_bd, m_eret,
        output trap, trap_code, trap_pc, trap_bd, eret_go, flush, npc_sel, busy
    );
endinterface

// File: rtl/cp0_trap_ctrl_irq_pending.sv
// Device interrupt capture: per-bit level follow or edge latch with ack clear.
module irq_pending #(
    parameter logic [5:0] EDGE_MASK = 6'b000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] irq_in,
    input  logic [5:0] irq_clr,
    output logic [5:0] hwint
);
    logic [5:0] prev_r;
    logic [5:0] hwint_r;
    logic [5:0] rise_s;
    logic [5:0] hwint_nx_s;

    // Next pending vector: a new rising edge beats a same-cycle ack on edge bits
    always_comb begin
        rise_s     = irq_in & ~prev_r;
        hwint_nx_s = (EDGE_MASK & (rise_s | (hwint_r & ~irq_clr)))
                   | (~EDGE_MASK & irq_in);
    end

    // Edge history and pending register
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_r  <= 6'b000000;
            hwint_r <= 6'b000000;
        end else begin
            prev_r  <= irq_in;
            hwint_r <= hwint_nx_s;
        end
    end

    assign hwint = hwint_r;
endmodule

// File: rtl/cp0_trap_ctrl.sv
// Trap sequencer: picks interrupt / exception / ERET for the M-stage
// instruction, drives CP0 and the redirect, then drains the pipeline.
module cp0_trap_ctrl
    import cp0_trap_ctrl_pkg::*;
#(
    parameter int          FLUSH_CYC    = 2,
    parameter logic [5:0]  EDGE_MASK    = 6'b000000,
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            irq_in,
    input  logic [5:0]            irq_clr,
    input  logic [5:0]            sr_im,
    input  logic                  sr_ie,
    input  logic                  sr_exl,
    output logic [5:0]            hwint,
    cp0_trap_ctrl_if.slave        bus
);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(FLUSH_CYC - 1);
    localparam bit               USE_HOLD  = (FLUSH_CYC > 1);

    state_e           state_r;
    state_e           state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic             ready_r;

    logic [5:0]  hwint_s;
    logic        accept_s;
    logic        int_req_s;
    logic        exc_req_s;
    logic        trap_s;
    logic [4:0]  trap_code_s;
    logic [31:0] trap_pc_s;
    logic        trap_bd_s;
    logic        eret_go_s;
    logic        flush_s;
    npc_sel_e    npc_sel_s;
    logic        busy_s;

    irq_pending #(.EDGE_MASK(EDGE_MASK)) u_irq_pending (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .irq_clr (irq_clr),
        .hwint   (hwint_s)
    );

    // Trap decision, CP0 outputs and drain-state next values
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        trap_s      = 1'b0;
        trap_code_s = 5'd0;
        trap_pc_s   = 32'd0;
        trap_bd_s   = 1'b0;
        eret_go_s   = 1'b0;
        flush_s     = 1'b0;
        npc_sel_s   = NPC_SEL_SEQ;
        busy_s      = 1'b0;

        // ready_r keeps the first cycle after reset quiet
        accept_s  = reset & ready_r & (state_r == IDLE) & bus.m_valid & ~bus.m_stall;
        int_req_s = sr_ie & ~sr_exl & (|(hwint_s & sr_im));
        exc_req_s = (bus.m_exccode != 5'd0);

        case (state_r)
            IDLE: begin
                if (accept_s && (int_req_s || exc_req_s)) begin
                    trap_s      = 1'b1;
                    trap_code_s = int_req_s ? EXC_INT : bus.m_exccode;
                    trap_pc_s   = epc_calc(bus.m_pc, bus.m_bd);
                    trap_bd_s   = bus.m_bd;
                    npc_sel_s   = NPC_SEL_HANDLER;
                    flush_s     = 1'b1;
                end else if (accept_s && bus.m_eret) begin
                    eret_go_s   = 1'b1;
                    npc_sel_s   = NPC_SEL_EPC;
                    flush_s     = 1'b1;
                end else begin
                    flush_s     = 1'b0;
                end
                if (flush_s && USE_HOLD) begin
                    state_nx_s = HOLD;
                    cnt_nx_s   = HOLD_LOAD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            HOLD: begin
                // Outputs stay quiet while reset is held; the register reset does the rest
                flush_s = reset;
                busy_s  = reset;
                if (cnt_r <= CNT_W'(1)) begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = CNT_W'(0);
                end else begin
                    cnt_nx_s   = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = CNT_W'(0);
            end
        endcase
    end

    // State, drain counter and post-reset guard
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_W'(0);
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            ready_r <= 1'b1;
        end
    end

    assign hwint         = hwint_s;
    assign bus.trap      = trap_s;
    assign bus.trap_code = trap_code_s;
    assign bus.trap_pc   = trap_pc_s;
    assign bus.trap_bd   = trap_bd_s;
    assign bus.eret_go   = eret_go_s;
    assign bus.flush     = flush_s;
    assign bus.npc_sel   = npc_sel_s;
    assign bus.busy      = busy_s;
endmodule

// File: tb/tb_cp0_trap_ctrl.sv
// Directed vector bench for cp0_trap_ctrl (FLUSH_CYC=2, irq bit 2 edge-latched).
module tb_cp0_trap_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] irq_in, irq_clr, sr_im, hwint;
    logic       sr_ie, sr_exl;
    int         n_chk  = 0;
    int         n_pass = 0;

    cp0_trap_ctrl_if bus_if();

    cp0_trap_ctrl #(
        .FLUSH_CYC    (2),
        .EDGE_MASK    (6'b000100),
        .HANDLER_ADDR (32'h0000_4180)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .irq_clr (irq_clr),
        .sr_im   (sr_im),
        .sr_ie   (sr_ie),
        .sr_exl  (sr_exl),
        .hwint   (hwint),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [5:0]  irq, clr, im;
        logic        ie, exl, val, stl;
        logic [4:0]  exc;
        logic [31:0] pc;
        logic        bd, er;
        logic [5:0]  e_hw;
        logic        e_trap;
        logic [4:0]  e_code;
        logic [31:0] e_pc;
        logic        e_bd, e_eret, e_flush;
        logic [1:0]  e_npc;
        logic        e_busy;
    } vec_t;

    localparam int NV = 38;
    vec_t tv[NV];

    function automatic vec_t mk(string nm, logic [5:0] irq, logic [5:0] clr, logic [5:0] im,
                                logic ie, logic exl, logic val, logic stl, logic [4:0] exc,
                                logic [31:0] pc, logic bd, logic er, logic [5:0] e_hw,
                                logic e_trap, logic [4:0] e_code, logic [31:0] e_pc, logic e_bd,
                                logic e_eret, logic e_flush, logic [1:0] e_npc, logic e_busy);
        vec_t v;
        v.nm = nm; v.irq = irq; v.clr = clr; v.im = im; v.ie = ie; v.exl = exl;
        v.val = val; v.stl = stl; v.exc = exc; v.pc = pc; v.bd = bd; v.er = er;
        v.e_hw = e_hw; v.e_trap = e_trap; v.e_code = e_code; v.e_pc = e_pc; v.e_bd = e_bd;
        v.e_eret = e_eret; v.e_flush = e_flush; v.e_npc = e_npc; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic drive(input logic [5:0] irq, input logic [5:0] clr, input logic [5:0] im,
                         input logic ie, input logic exl, input logic val, input logic stl,
                         input logic [4:0] exc, input logic [31:0] pc, input logic bd, input logic er);
        irq_in = irq; irq_clr = clr; sr_im = im; sr_ie = ie; sr_exl = exl;
        bus_if.m_valid = val; bus_if.m_stall = stl; bus_if.m_exccode = exc;
        bus_if.m_pc = pc; bus_if.m_bd = bd; bus_if.m_eret = er;
    endtask

    task automatic check(input string nm, input logic [5:0] e_hw, input logic e_trap,
                         input logic [4:0] e_code, input logic [31:0] e_pc, input logic e_bd,
                         input logic e_eret, input logic e_flush, input logic [1:0] e_npc,
                         input logic e_busy);
        logic ok;
        ok = ({hwint, bus_if.trap, bus_if.eret_go, bus_if.flush, bus_if.npc_sel, bus_if.busy}
              === {e_hw, e_trap, e_eret, e_flush, e_npc, e_busy});
        if (e_trap)
            ok = ok && ({bus_if.trap_code, bus_if.trap_pc, bus_if.trap_bd} === {e_code, e_pc, e_bd});
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got hw=%b trap=%b code=%0d pc=%h bd=%b eret=%b flush=%b npc=%b busy=%b; expected hw=%b trap=%b code=%0d pc=%h bd=%b eret=%b flush=%b npc=%b busy=%b",
                      nm, hwint, bus_if.trap, bus_if.trap_code, bus_if.trap_pc, bus_if.trap_bd,
                      bus_if.eret_go, bus_if.flush, bus_if.npc_sel, bus_if.busy,
                      e_hw, e_trap, e_code, e_pc, e_bd, e_eret, e_flush, e_npc, e_busy);
    endtask

    initial begin
        // name, irq, clr, im, ie, exl, val, stl, exc, pc, bd, er | hw, trap, code, epc, bd, eret, flush, npc, busy
        tv[0]  = mk("lvl_raise",       6'h01,6'h00,6'h01,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3008,1'b0,1'b0, 6'h00,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[1]  = mk("lvl_int",         6'h01,6'h00,6'h01,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3008,1'b0,1'b0, 6'h01,1'b1,5'd0, 32'h3008,    1'b0,1'b0,1'b1,2'b01,1'b0);
        tv[2]  = mk("lvl_hold",        6'h00,6'h00,6'h01,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3008,1'b0,1'b0, 6'h01,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b1,2'b00,1'b1);
        tv[3]  = mk("lvl_idle",        6'h00,6'h00,6'h01,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3008,1'b0,1'b0, 6'h00,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[4]  = mk("dslot_exc",       6'h00,6'h00,6'h00,1'b1,1'b0,1'b1,1'b0,5'd10,32'h300C,1'b1,1'b0, 6'h00,1'b1,5'd10,32'h3008,    1'b1,1'b0,1'b1,2'b01,1'b0);
        tv[5]  = mk("dslot_hold",      6'h00,6'h00,6'h00,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3000,1'b0,1'b0, 6'h00,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b1,2'b00,1'b1);
        tv[6]  = mk("pri_raise",       6'h01,6'h00,6'h01,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3010,1'b0,1'b0, 6'h00,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[7]  = mk("int_over_exc",    6'h01,6'h00,6'h01,1'b1,1'b0,1'b1,1'b0,5'd4, 32'h3010,1'b0,1'b0, 6'h01,1'b1,5'd0, 32'h3010,    1'b0,1'b0,1'b1,2'b01,1'b0);
        tv[8]  = mk("hold_suppress",   6'h01,6'h00,6'h01,1'b1,1'b0,1'b1,1'b0,5'd4, 32'h3010,1'b0,1'b0, 6'h01,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b1,2'b00,1'b1);
        tv[9]  = mk("int_after_hold",  6'h00,6'h00,6'h01,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3014,1'b0,1'b0, 6'h01,1'b1,5'd0, 32'h3014,    1'b0,1'b0,1'b1,2'b01,1'b0);
        tv[10] = mk("hold_b",          6'h00,6'h00,6'h01,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3014,1'b0,1'b0, 6'h00,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b1,2'b00,1'b1);
        tv[11] = mk("exl_raise",       6'h01,6'h00,6'h01,1'b1,1'b1,1'b1,1'b0,5'd0, 32'h3018,1'b0,1'b0, 6'h00,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[12] = mk("exl_mask",        6'h01,6'h00,6'h01,1'b1,1'b1,1'b1,1'b0,5'd0, 32'h3018,1'b0,1'b0, 6'h01,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[13] = mk("im_mask",         6'h01,6'h00,6'h02,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3018,1'b0,1'b0, 6'h01,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[14] = mk("ie_mask",         6'h01,6'h00,6'h01,1'b0,1'b0,1'b1,1'b0,5'd0, 32'h3018,1'b0,1'b0, 6'h01,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[15] = mk("stall_mask",      6'h01,6'h00,6'h01,1'b1,1'b0,1'b1,1'b1,5'd0, 32'h3018,1'b0,1'b0, 6'h01,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[16] = mk("bubble_mask",     6'h01,6'h00,6'h01,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h3018,1'b0,1'b0, 6'h01,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[17] = mk("unmask_take",     6'h00,6'h00,6'h01,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3020,1'b0,1'b0, 6'h01,1'b1,5'd0, 32'h3020,    1'b0,1'b0,1'b1,2'b01,1'b0);
        tv[18] = mk("hold_c",          6'h00,6'h00,6'h01,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3020,1'b0,1'b0, 6'h00,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b1,2'b00,1'b1);
        tv[19] = mk("edge_pulse",      6'h04,6'h00,6'h00,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3024,1'b0,1'b0, 6'h00,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[20] = mk("edge_latched",    6'h00,6'h00,6'h00,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3024,1'b0,1'b0, 6'h04,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[21] = mk("edge_stays",      6'h00,6'h00,6'h00,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3024,1'b0,1'b0, 6'h04,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[22] = mk("edge_clr",        6'h00,6'h04,6'h00,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3024,1'b0,1'b0, 6'h04,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[23] = mk("edge_cleared",    6'h00,6'h00,6'h00,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3024,1'b0,1'b0, 6'h00,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[24] = mk("edge_set_clr",    6'h04,6'h04,6'h00,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3024,1'b0,1'b0, 6'h00,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[25] = mk("edge_set_wins",   6'h00,6'h00,6'h00,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3024,1'b0,1'b0, 6'h04,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[26] = mk("edge_clr_b",      6'h01,6'h05,6'h00,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3024,1'b0,1'b0, 6'h04,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[27] = mk("lvl_ignores_clr", 6'h01,6'h01,6'h00,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3024,1'b0,1'b0, 6'h01,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[28] = mk("lvl_drop",        6'h00,6'h00,6'h00,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3024,1'b0,1'b0, 6'h01,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[29] = mk("eret",            6'h00,6'h00,6'h00,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3028,1'b0,1'b1, 6'h00,1'b0,5'd0, 32'h0,       1'b0,1'b1,1'b1,2'b10,1'b0);
        tv[30] = mk("eret_hold",       6'h00,6'h00,6'h00,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3028,1'b0,1'b1, 6'h00,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b1,2'b00,1'b1);
        tv[31] = mk("eret_vs_exc",     6'h00,6'h00,6'h00,1'b1,1'b0,1'b1,1'b0,5'd8, 32'h3030,1'b0,1'b1, 6'h00,1'b1,5'd8, 32'h3030,    1'b0,1'b0,1'b1,2'b01,1'b0);
        tv[32] = mk("hold_d",          6'h00,6'h00,6'h00,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3030,1'b0,1'b0, 6'h00,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b1,2'b00,1'b1);
        tv[33] = mk("quiet",           6'h00,6'h00,6'h00,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3034,1'b0,1'b0, 6'h00,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0,2'b00,1'b0);
        tv[34] = mk("exc_under_exl",   6'h00,6'h00,6'h00,1'b1,1'b1,1'b1,1'b0,5'd12,32'h3041,1'b0,1'b0, 6'h00,1'b1,5'd12,32'h3040,    1'b0,1'b0,1'b1,2'b01,1'b0);
        tv[35] = mk("hold_e",          6'h00,6'h00,6'h00,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3044,1'b0,1'b0, 6'h00,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b1,2'b00,1'b1);
        tv[36] = mk("epc_wrap",        6'h00,6'h00,6'h00,1'b1,1'b0,1'b1,1'b0,5'd1, 32'h0002,1'b1,1'b0, 6'h00,1'b1,5'd1, 32'hFFFFFFFC,1'b1,1'b0,1'b1,2'b01,1'b0);
        tv[37] = mk("hold_f",          6'h00,6'h00,6'h00,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3048,1'b0,1'b0, 6'h00,1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b1,2'b00,1'b1);

        // Reset with a pending exception on M: everything stays quiet
        reset = 1'b0;
        drive(6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd10, 32'h3000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_reset", 6'h00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("post_reset", 6'h00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // One vector per cycle: drive after the edge, check mid-cycle
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            drive(tv[i].irq, tv[i].clr, tv[i].im, tv[i].ie, tv[i].exl, tv[i].val, tv[i].stl,
                  tv[i].exc, tv[i].pc, tv[i].bd, tv[i].er);
            @(negedge clk);
            check(tv[i].nm, tv[i].e_hw, tv[i].e_trap, tv[i].e_code, tv[i].e_pc, tv[i].e_bd,
                  tv[i].e_eret, tv[i].e_flush, tv[i].e_npc, tv[i].e_busy);
        end

        // Reset asserted inside the drain window
        @(posedge clk); #1;
        drive(6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 32'h4000, 1'b0, 1'b0);
        @(negedge clk);
        check("rst_seq_trap", 6'h00, 1'b1, 5'd3, 32'h4000, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_hold", 6'h00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("rst_hold_abort", 6'h00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_recover", 6'h00, 1'b1, 5'd3, 32'h4000, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        @(posedge clk); #1 bus_if.m_exccode = 5'd0;
        @(negedge clk);
        check("rst_recover_hold", 6'h00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
